// File: rtl/qpsk_demap_ber.sv
// Gray-QPSK hard-decision demapper with tx-bit alignment FIFO and windowed BER/SER counters.
// Optional soft outputs (negated, saturated sample MSBs) are built when QPSK_SOFT_OUT_EN is defined.
module qpsk_demap_ber #(
  parameter int BI    = 24,
  parameter int DEPTH = 16,
  parameter int CNT_W = 32,
  parameter int LLR_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [CNT_W-1:0]        window_len,
  input  logic                    tx_valid,
  input  logic [1:0]              tx_bits,
  input  logic                    sym_valid,
  input  logic signed [BI-1:0]    y_real,
  input  logic signed [BI-1:0]    y_imag,
  output logic                    dec_valid,
  output logic [1:0]              dec_bits,
  output logic [LLR_W-1:0]        llr_real,
  output logic [LLR_W-1:0]        llr_imag,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        sym_count,
  output logic [CNT_W-1:0]        bit_errors,
  output logic [CNT_W-1:0]        sym_errors,
  output logic                    underflow,
  output logic                    overflow
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t r_state;
  state_t w_state_next;

  logic [1:0]       r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_fill;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic [1:0]       w_ref;

  logic [BI-1:0]    w_y [2];
  logic [1:0]       w_dec;
  logic [1:0]       w_diff;
  logic [1:0]       w_nerr;
  logic             w_compare;
  logic             w_window_hit;

  logic             r_dec_valid;
  logic [1:0]       r_dec_bits;
  logic [CNT_W-1:0] r_sym_count;
  logic [CNT_W-1:0] r_bit_errors;
  logic [CNT_W-1:0] r_sym_errors;
  logic [CNT_W-1:0] r_win_len;
  logic [CNT_W-1:0] w_sym_count_inc;
  logic             r_underflow;
  logic             r_overflow;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  assign w_y[0] = y_real;
  assign w_y[1] = y_imag;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rail
      assign w_dec[gi] = w_y[gi][BI-1];
    end
  endgenerate

  // Pop is evaluated before push, so a full FIFO still accepts a push when a pop coincides.
  assign w_empty = (r_fill == '0);
  assign w_full  = (r_fill == (AW+1)'(DEPTH));
  assign w_pop   = sym_valid & ~w_empty;
  assign w_push  = tx_valid & (~w_full | w_pop);
  assign w_ref   = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= tx_bits;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_fill <= r_fill + (AW+1)'(1);
      else if (w_pop && !w_push) r_fill <= r_fill - (AW+1)'(1);
    end
  end

  assign w_diff          = w_dec ^ w_ref;
  assign w_nerr          = {1'b0, w_diff[1]} + {1'b0, w_diff[0]};
  assign w_compare       = w_pop & (r_state == S_RUN);
  assign w_sym_count_inc = sat_add(r_sym_count, 2'd1);
  assign w_window_hit    = (w_sym_count_inc == r_win_len);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_RUN;
      S_RUN: begin
        if (start)                          w_state_next = S_RUN;
        else if (w_compare && w_window_hit) w_state_next = S_DONE;
      end
      S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // start takes priority over a coincident compare: the new window begins from zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sym_count  <= '0;
      r_bit_errors <= '0;
      r_sym_errors <= '0;
      r_win_len    <= '0;
    end else if (start) begin
      r_sym_count  <= '0;
      r_bit_errors <= '0;
      r_sym_errors <= '0;
      r_win_len    <= (window_len == '0) ? CNT_W'(1) : window_len;
    end else if (w_compare) begin
      r_sym_count  <= w_sym_count_inc;
      r_bit_errors <= sat_add(r_bit_errors, w_nerr);
      if (w_nerr != 2'd0) r_sym_errors <= sat_add(r_sym_errors, 2'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_underflow <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (start) begin
        r_underflow <= 1'b0;
        r_overflow  <= 1'b0;
      end
      if (sym_valid && w_empty)           r_underflow <= 1'b1;
      if (tx_valid && w_full && !w_pop)   r_overflow  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_dec_valid <= 1'b0;
      r_dec_bits  <= 2'b00;
    end else begin
      r_dec_valid <= sym_valid;
      if (sym_valid) r_dec_bits <= w_dec;
    end
  end

`ifdef QPSK_SOFT_OUT_EN
  logic [LLR_W-1:0] w_llr [2];
  logic [LLR_W-1:0] r_llr_real;
  logic [LLR_W-1:0] r_llr_imag;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_soft
      logic [LLR_W-1:0] w_top;
      assign w_top     = w_y[gi][BI-1 -: LLR_W];
      // Negating the most-negative code would wrap, so it clamps to the largest positive value.
      assign w_llr[gi] = (w_top == {1'b1, {(LLR_W-1){1'b0}}}) ? {1'b0, {(LLR_W-1){1'b1}}} : -w_top;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_llr_real <= '0;
      r_llr_imag <= '0;
    end else if (sym_valid) begin
      r_llr_real <= w_llr[0];
      r_llr_imag <= w_llr[1];
    end
  end

  assign llr_real = r_llr_real;
  assign llr_imag = r_llr_imag;
`else
  assign llr_real = '0;
  assign llr_imag = '0;
`endif

  assign dec_valid  = r_dec_valid;
  assign dec_bits   = r_dec_bits;
  assign busy       = (r_state == S_RUN);
  assign done       = (r_state == S_DONE);
  assign sym_count  = r_sym_count;
  assign bit_errors = r_bit_errors;
  assign sym_errors = r_sym_errors;
  assign underflow  = r_underflow;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_qpsk_demap_ber.sv
// Scoreboard bench for qpsk_demap_ber: a queue-based reference model predicts per-cycle status and
// per-symbol decisions; a monitor compares them one cycle after each drive.
module tb_qpsk_demap_ber;
  localparam int BI    = 24;
  localparam int DEPTH = 16;
  localparam int CNT_W = 8;
  localparam int LLR_W = 8;

  logic              clk;
  logic              reset;
  logic              start;
  logic [CNT_W-1:0]  window_len;
  logic              tx_valid;
  logic [1:0]        tx_bits;
  logic              sym_valid;
  logic [BI-1:0]     y_real;
  logic [BI-1:0]     y_imag;
  logic              dec_valid;
  logic [1:0]        dec_bits;
  logic [LLR_W-1:0]  llr_real;
  logic [LLR_W-1:0]  llr_imag;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  sym_count;
  logic [CNT_W-1:0]  bit_errors;
  logic [CNT_W-1:0]  sym_errors;
  logic              underflow;
  logic              overflow;

  qpsk_demap_ber #(.BI(BI), .DEPTH(DEPTH), .CNT_W(CNT_W), .LLR_W(LLR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .window_len(window_len),
    .tx_valid(tx_valid), .tx_bits(tx_bits), .sym_valid(sym_valid),
    .y_real(y_real), .y_imag(y_imag), .dec_valid(dec_valid), .dec_bits(dec_bits),
    .llr_real(llr_real), .llr_imag(llr_imag), .busy(busy), .done(done),
    .sym_count(sym_count), .bit_errors(bit_errors), .sym_errors(sym_errors),
    .underflow(underflow), .overflow(overflow)
  );

  typedef struct {
    bit dv; bit bsy; bit dn; bit uf; bit of;
    int sc; int be; int se;
  } st_t;
  typedef struct { int dec; int lr; int li; } dec_t;

  st_t  st_q[$];
  dec_t dec_q[$];
  st_t  mon_e;
  dec_t mon_d;

  // Reference model: behavioural FIFO plus window bookkeeping
  int ref_q[$];
  int m_phase;   // 0 idle, 1 measuring, 2 window just finished
  int m_sc, m_be, m_se, m_win;
  bit m_uf, m_of;

  int n_cmp = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  function automatic int llr_model(int y);
`ifdef QPSK_SOFT_OUT_EN
    int top, n, mx;
    mx  = (1 << (LLR_W-1)) - 1;
    top = y >>> (BI-LLR_W);
    n   = -top;
    if (n > mx) n = mx;
    return n & ((1 << LLR_W) - 1);
`else
    return (y & 0) * 0;
`endif
  endfunction

  function automatic int min_sat(int v);
    int mx;
    mx = (1 << CNT_W) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic step(input bit rn, input bit st, input int wl, input bit txv, input bit [1:0] txb,
                      input bit sv, input logic [BI-1:0] yr, input logic [BI-1:0] yi);
    int ry, iy, refb, errs, dec;
    bit cmp;
    st_t e;
    dec_t d;
    @(negedge clk);
    reset = rn; start = st; window_len = wl[CNT_W-1:0];
    tx_valid = txv; tx_bits = txb; sym_valid = sv; y_real = yr; y_imag = yi;
    ry = $signed(yr);
    iy = $signed(yi);
    e.dv = 1'b0;
    if (!rn) begin
      ref_q.delete();
      m_phase = 0; m_sc = 0; m_be = 0; m_se = 0; m_win = 0;
      m_uf = 1'b0; m_of = 1'b0;
    end else begin
      dec  = ((iy < 0) ? 2 : 0) + ((ry < 0) ? 1 : 0);
      cmp  = 1'b0;
      refb = 0;
      if (st) begin m_uf = 1'b0; m_of = 1'b0; end
      if (sv) begin
        if (ref_q.size() == 0) m_uf = 1'b1;
        else begin refb = ref_q.pop_front(); cmp = 1'b1; end
      end
      if (txv) begin
        if (ref_q.size() < DEPTH) ref_q.push_back(int'(txb));
        else m_of = 1'b1;
      end
      if (st) begin
        m_sc = 0; m_be = 0; m_se = 0;
        m_win = (wl == 0) ? 1 : wl;
        m_phase = 1;
      end else if (m_phase == 1) begin
        if (cmp) begin
          errs = ((dec & 1) != (refb & 1) ? 1 : 0) + ((dec & 2) != (refb & 2) ? 1 : 0);
          m_sc = min_sat(m_sc + 1);
          m_be = min_sat(m_be + errs);
          if (errs != 0) m_se = min_sat(m_se + 1);
          if (m_sc == m_win) m_phase = 2;
        end
      end else if (m_phase == 2) begin
        m_phase = 0;
      end
      e.dv = sv;
      if (sv) begin
        d.dec = dec; d.lr = llr_model(ry); d.li = llr_model(iy);
        dec_q.push_back(d);
      end
    end
    e.bsy = (m_phase == 1); e.dn = (m_phase == 2);
    e.uf = m_uf; e.of = m_of;
    e.sc = m_sc; e.be = m_be; e.se = m_se;
    st_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1, 0, 0, 0, 2'b00, 0, '0, '0);
  endtask

  function automatic logic [BI-1:0] rand_y();
    int v;
    logic [31:0] r;
    case ($urandom_range(0, 4))
      0: return '0;
      1: return {1'b1, {(BI-1){1'b0}}};
      2: begin v = int'($urandom_range(0, 16)) - 8; return v[BI-1:0]; end
      default: begin r = $urandom(); return r[BI-1:0]; end
    endcase
  endfunction

  // Monitor: consumes one status expectation per clock, and one decision per dec_valid
  always @(posedge clk) begin
    #1;
    if (st_q.size() > 0) begin
      mon_e = st_q.pop_front();
      check("dec_valid", int'(dec_valid), int'(mon_e.dv));
      check("busy", int'(busy), int'(mon_e.bsy));
      check("done", int'(done), int'(mon_e.dn));
      check("underflow", int'(underflow), int'(mon_e.uf));
      check("overflow", int'(overflow), int'(mon_e.of));
      check("sym_count", int'(sym_count), mon_e.sc);
      check("bit_errors", int'(bit_errors), mon_e.be);
      check("sym_errors", int'(sym_errors), mon_e.se);
      if (dec_valid) begin
        if (dec_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL dec_unexpected: got dec_valid=1 expected no decision pending");
        end else begin
          mon_d = dec_q.pop_front();
          check("dec_bits", int'(dec_bits), mon_d.dec);
          check("llr_real", int'(llr_real), mon_d.lr);
          check("llr_imag", int'(llr_imag), mon_d.li);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; start = 1'b0; window_len = '0; tx_valid = 1'b0; tx_bits = 2'b00;
    sym_valid = 1'b0; y_real = '0; y_imag = '0;

    step(0, 0, 0, 0, 2'b00, 0, '0, '0);
    step(0, 0, 0, 0, 2'b00, 0, '0, '0);
    idle(1);

    // Clean window of 4, then start again in the DONE cycle
    step(1, 1, 4, 0, 2'b00, 0, '0, '0);
    for (int k = 0; k < 4; k++) step(1, 0, 0, 1, 2'b00, 0, '0, '0);
    for (int k = 0; k < 4; k++) step(1, 0, 0, 0, 2'b00, 1, 24'd1000, 24'd1000);
    step(1, 1, 4, 0, 2'b00, 0, '0, '0);

    // Mixed-sign samples against all-zero reference, including an exact zero
    for (int k = 0; k < 4; k++) step(1, 0, 0, 1, 2'b00, 0, '0, '0);
    step(1, 0, 0, 0, 2'b00, 1, -24'sd5, 24'sd7);
    step(1, 0, 0, 0, 2'b00, 1, -24'sd5, -24'sd7);
    step(1, 0, 0, 0, 2'b00, 1, 24'sd0, 24'sd0);
    step(1, 0, 0, 0, 2'b00, 1, 24'sd3, -24'sd1);
    idle(2);

    // Symbol with empty FIFO, with soft-path corner samples
    step(1, 0, 0, 0, 2'b00, 1, 24'h800000, 24'h100000);
    idle(1);

    // Fill to DEPTH, push+pop at full, then push-only at full
    step(1, 1, 100, 0, 2'b00, 0, '0, '0);
    for (int k = 0; k < DEPTH; k++) step(1, 0, 0, 1, k[1:0], 0, '0, '0);
    step(1, 0, 0, 1, 2'b11, 1, 24'd9, -24'sd9);
    step(1, 0, 0, 1, 2'b10, 0, '0, '0);
    step(1, 0, 0, 0, 2'b00, 1, -24'sd100, 24'd100);

    // Reset for two cycles in the middle of a window
    step(0, 0, 0, 0, 2'b00, 0, '0, '0);
    step(0, 0, 0, 0, 2'b00, 0, '0, '0);
    idle(1);

    // window_len of zero behaves as one
    step(1, 1, 0, 0, 2'b00, 0, '0, '0);
    step(1, 0, 0, 1, 2'b01, 0, '0, '0);
    step(1, 0, 0, 0, 2'b00, 1, 24'd5, 24'd5);
    idle(2);

    // Error counter saturation: every symbol carries two bit errors
    step(1, 1, 200, 0, 2'b00, 0, '0, '0);
    step(1, 0, 0, 1, 2'b11, 0, '0, '0);
    for (int k = 0; k < 200; k++) step(1, 0, 0, 1, 2'b11, 1, 24'd5, 24'd5);
    idle(2);

    for (int k = 0; k < 2500; k++) begin
      if ($urandom_range(0, 59) == 0)
        step(1, 1, int'($urandom_range(0, 24)), 0, 2'b00, 0, '0, '0);
      else if ($urandom_range(0, 299) == 0)
        step(0, 0, 0, 0, 2'b00, 0, '0, '0);
      else
        step(1, 0, 0, ($urandom_range(0, 99) < 55), 2'($urandom_range(0, 3)),
             ($urandom_range(0, 99) < 50), rand_y(), rand_y());
    end
    idle(3);

    @(posedge clk);
    #2;
    check("dec_queue_drained", dec_q.size(), 0);
    check("status_queue_drained", st_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
